ccu_snoop_ctrl: RTL and testbench
=================================

Name: ccu_snoop_ctrl

Overview:
- Parametrised snoop engine for the CCU. Takes one snoop job from the CCU front-end and broadcasts the AC request to every snooped master except the initiator. Tracks AC, CR and CD handshakes independently per port.
- Merges the CR responses into a single result. Forwards one cache line of snoop data (CD) from the lowest-index responding port and drains CD from all other data-bearing ports.
- Replaces the fixed single-FSM snoop sequencing in the CCU front-end. The front-end keeps only the AXI request/response routing.

Parameters:
- NoMstPorts, 4, number of snooped ACE masters (>=1).
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- DataBeats, 4, CD beats per cache line (>=1).
- IdxWidth, $clog2(NoMstPorts) (min 1), initiator index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- job_valid_i  in  1  snoop job valid
- job_ready_o  out  1  job accepted
- job_addr_i  in  AddrWidth  snoop address
- job_snoop_i  in  4  ACSNOOP encoding
- job_prot_i  in  3  protection
- job_init_i  in  IdxWidth  initiator port (not snooped)
- ac_valid_o  out  NoMstPorts  per-port AC valid
- ac_ready_i  in  NoMstPorts  per-port AC ready
- ac_addr_o  out  AddrWidth  broadcast address
- ac_snoop_o  out  4  broadcast snoop
- ac_prot_o  out  3  broadcast prot
- cr_valid_i  in  NoMstPorts  CR valid
- cr_ready_o  out  NoMstPorts  CR ready
- cr_resp_i  in  5*NoMstPorts  CRRESP per port
- cd_valid_i  in  NoMstPorts  CD valid
- cd_ready_o  out  NoMstPorts  CD ready
- cd_data_i  in  DataWidth*NoMstPorts  CD data
- cd_last_i  in  NoMstPorts  CD last
- res_valid_o  out  1  merged result valid
- res_ready_i  in  1  result accepted
- res_data_o  out  1  any port has DataTransfer
- res_dirty_o  out  1  OR of PassDirty
- res_shared_o  out  1  OR of IsShared
- res_err_o  out  1  OR of Error, or CD last mismatch
- dat_valid_o  out  1  forwarded CD beat valid
- dat_ready_i  in  1  forwarded beat accepted
- dat_data_o  out  DataWidth  forwarded beat
- dat_last_o  out  1  final beat
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all masks 0. Every output is 0, except the broadcast AC fields, which are also 0.
- CRRESP bit assignment: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- IDLE:
  - job_ready_o = 1.
  - On job_valid_i, register addr, snoop, prot and init.
  - snp_mask = all ones with bit job_init_i cleared. If job_init_i >= NoMstPorts, no bit is cleared.
  - If snp_mask == 0, go to RESULT with all result bits 0. Otherwise go to SNOOP.
- SNOOP:
  - ac_valid_o[i] = snp_mask[i] & ~ac_done[i].
  - ac_done[i] sets on ac_valid_o[i] & ac_ready_i[i].
  - cr_ready_o[i] = ac_done[i] & ~cr_done[i]. A CR arriving before that port's AC handshake is not accepted.
  - On a CR handshake, set cr_done[i]; store data_mask[i] = resp[0]; OR resp[1], [2], [3] into the result registers.
  - When cr_done == snp_mask (including a same-cycle final handshake), go to RESULT.
- RESULT:
  - res_valid_o = 1. Outputs are stable until res_ready_i.
  - res_data_o = |data_mask.
  - sel = lowest set index of data_mask.
  - On handshake, go to DATA if data_mask != 0, else IDLE.
- DATA:
  - Selected port: dat_valid_o = cd_valid_i[sel], cd_ready_o[sel] = dat_ready_i, dat_data_o = cd_data_i[sel].
  - Beat counter counts 0..DataBeats-1. dat_last_o = (cnt == DataBeats-1).
  - If cd_last_i[sel] disagrees with dat_last_o on a handshake, res_err_o is set sticky (visible on the next job's result, cleared at that job's IDLE accept). The counter governs completion.
  - Other data_mask ports: cd_ready_o = 1 until their cd_last_i handshake; data is dropped; drain_done[i] sets on that handshake.
  - Go to IDLE when the selected port's final beat has handshaked and all drain ports are done, including same-cycle completions.
- Masks (ac_done, cr_done, data_mask, drain_done) and the beat counter clear on entry to IDLE.
- Reset mid-job: returns to IDLE next edge with all outputs 0. No pending handshake is honoured.

Decomposition:
- ccu_pkg holds:
  - crresp_t packed struct, 5 bits, fields as listed under Behaviour.
  - ACSNOOP constants: ReadShared 4'b0001, CleanInvalid 4'b1001, MakeInvalid 4'b1101.
  - State enum: IDLE, SNOOP, RESULT, DATA.
- One sub-module: ccu_lzc_sel, a lowest-set-bit index finder over NoMstPorts bits that returns index plus empty flag. Used for sel.

Test Plan:
- N=4, init=0, snoop 0001, ports 1..3 ready the same cycle, CR = 0 on all.
  -> ac_valid_o = 1110 for one cycle, res_data_o = 0, res_valid_o high, back in IDLE 1 cycle after res_ready_i, no dat_valid_o.
- Staggered AC: port 2 ac_ready_i delayed 5 cycles.
  -> ac_valid_o[2] held for 5 cycles; cr_ready_o[2] stays low until its AC handshake.
- Ports 2 and 3 return DataTransfer, with port 3 PassDirty.
  -> sel = 2; 4 beats of port-2 data 0xA0..0xA3 forwarded with dat_last_o on beat 3; port-3 CD drained with none forwarded; res_dirty_o = 1.
- dat_ready_i toggled 1/0 each cycle during DATA.
  -> no beat lost or duplicated; cd_ready_o[sel] mirrors dat_ready_i.
- N=1, init=0.
  -> IDLE to RESULT directly, res_data_o = 0, no ac_valid_o.
- rst_i asserted in DATA after 2 beats.
  -> next cycle: busy_o = 0, all valid/ready outputs 0, next job starts with beat counter 0.

Source files
------------

// File: rtl/ccu_pkg.sv
// ----------------------------------------------------------------------------
// ccu_pkg
// Shared types and constants for the CCU snoop engine.
//   crresp_t : decoded CRRESP field layout (5 bits, bit 0 = DataTransfer)
//   ACSNOOP  : the snoop encodings the front-end issues
//   state_e  : snoop engine sequencing states
// ----------------------------------------------------------------------------
package ccu_pkg;

    typedef struct packed {
        logic was_unique;  // [4]
        logic is_shared;   // [3]
        logic pass_dirty;  // [2]
        logic error;       // [1]
        logic data_xfer;   // [0]
    } crresp_t;

    localparam int CrrespWidth = $bits(crresp_t);

    localparam logic [3:0] ReadShared   = 4'b0001;
    localparam logic [3:0] CleanInvalid = 4'b1001;
    localparam logic [3:0] MakeInvalid  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNOOP  = 2'd1,
        RESULT = 2'd2,
        DATA   = 2'd3
    } state_e;

endpackage

// File: rtl/ccu_lzc_sel.sv
// ----------------------------------------------------------------------------
// ccu_lzc_sel
// Lowest-set-bit finder.
//   bits  : input vector (Width bits)
//   idx   : index of the lowest set bit (0 when empty)
//   empty : no bit set
// ----------------------------------------------------------------------------
module ccu_lzc_sel #(
    parameter int Width    = 4,
    parameter int IdxWidth = 2
) (
    input  logic [Width-1:0]    bits,
    output logic [IdxWidth-1:0] idx,
    output logic                empty
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        empty = 1'b1;
        for (int i = Width - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx   = IdxWidth'(i);
                empty = 1'b0;
            end else begin
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/ccu_snoop_ctrl.sv
// ----------------------------------------------------------------------------
// ccu_snoop_ctrl
// Snoop engine: broadcasts one snoop job on AC to every master except the
// initiator, collects and merges CR responses, forwards one cache line of CD
// from the lowest-index data-bearing port and drains CD from the others.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   job_*                         snoop job from the front-end (valid/ready)
//   ac_*                          per-port AC valid/ready, broadcast payload
//   cr_*                          per-port CR valid/ready/resp
//   cd_*                          per-port CD valid/ready/data/last
//   res_*                         merged snoop result (valid/ready)
//   dat_*                         forwarded cache line beats (valid/ready)
//   busy_o                        engine not idle
// ----------------------------------------------------------------------------
module ccu_snoop_ctrl
    import ccu_pkg::*;
#(
    parameter int NoMstPorts = 4,
    parameter int AddrWidth  = 64,
    parameter int DataWidth  = 64,
    parameter int DataBeats  = 4,
    parameter int IdxWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              job_valid_i,
    output logic                              job_ready_o,
    input  logic [AddrWidth-1:0]              job_addr_i,
    input  logic [3:0]                        job_snoop_i,
    input  logic [2:0]                        job_prot_i,
    input  logic [IdxWidth-1:0]               job_init_i,
    output logic [NoMstPorts-1:0]             ac_valid_o,
    input  logic [NoMstPorts-1:0]             ac_ready_i,
    output logic [AddrWidth-1:0]              ac_addr_o,
    output logic [3:0]                        ac_snoop_o,
    output logic [2:0]                        ac_prot_o,
    input  logic [NoMstPorts-1:0]             cr_valid_i,
    output logic [NoMstPorts-1:0]             cr_ready_o,
    input  logic [CrrespWidth*NoMstPorts-1:0] cr_resp_i,
    input  logic [NoMstPorts-1:0]             cd_valid_i,
    output logic [NoMstPorts-1:0]             cd_ready_o,
    input  logic [DataWidth*NoMstPorts-1:0]   cd_data_i,
    input  logic [NoMstPorts-1:0]             cd_last_i,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic                              res_data_o,
    output logic                              res_dirty_o,
    output logic                              res_shared_o,
    output logic                              res_err_o,
    output logic                              dat_valid_o,
    input  logic                              dat_ready_i,
    output logic [DataWidth-1:0]              dat_data_o,
    output logic                              dat_last_o,
    output logic                              busy_o
);

    localparam int CntWidth = (DataBeats > 1) ? $clog2(DataBeats) : 1;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(DataBeats - 1);

    state_e state_r, state_s;

    logic [AddrWidth-1:0]  addr_r;
    logic [3:0]            snoop_r;
    logic [2:0]            prot_r;
    logic [NoMstPorts-1:0] snp_mask_r, ac_done_r, cr_done_r, data_mask_r, drain_done_r;
    logic                  dirty_r, shared_r, err_r;
    // CD last mismatch seen on the previous line; reported on the next result.
    logic                  last_err_r;
    logic [CntWidth-1:0]   cnt_r;
    logic                  sel_done_r;

    logic [NoMstPorts-1:0] new_mask_s, ac_hs_s, cr_ready_s, cr_hs_s, cr_data_s;
    logic                  cr_err_s, cr_dirty_s, cr_shared_s, was_unique_unused_s;
    crresp_t               resp_s [NoMstPorts];
    logic [IdxWidth-1:0]   sel_idx_s;
    logic                  sel_empty_s;
    logic [NoMstPorts-1:0] sel_oh_s, drain_ports_s, drain_ready_s, drain_hs_s;
    logic                  cd_valid_sel_s, cd_last_sel_s, sel_active_s;
    logic                  dat_valid_s, dat_last_s, dat_hs_s, all_drain_s, sel_fin_s;
    logic [DataWidth-1:0]  dat_data_s;

    for (genvar g = 0; g < NoMstPorts; g++) begin : g_resp
        assign resp_s[g] = crresp_t'(cr_resp_i[CrrespWidth*g +: CrrespWidth]);
    end

    // Snoop every port except the initiator; out-of-range initiator clears nothing.
    always_comb begin
        new_mask_s = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            if (int'(job_init_i) == i) begin
                new_mask_s[i] = 1'b0;
            end else begin
                new_mask_s[i] = 1'b1;
            end
        end
    end

    assign ac_valid_o = (state_r == SNOOP) ? (snp_mask_r & ~ac_done_r) : '0;
    assign ac_hs_s    = ac_valid_o & ac_ready_i;
    // CR is only accepted after that port's own AC handshake.
    assign cr_ready_s = (state_r == SNOOP) ? (ac_done_r & ~cr_done_r) : '0;
    assign cr_hs_s    = cr_ready_s & cr_valid_i;
    assign cr_ready_o = cr_ready_s;

    assign ac_addr_o  = addr_r;
    assign ac_snoop_o = snoop_r;
    assign ac_prot_o  = prot_r;

    // Merge the CR fields of the ports handshaking this cycle.
    always_comb begin
        cr_data_s           = '0;
        cr_err_s            = 1'b0;
        cr_dirty_s          = 1'b0;
        cr_shared_s         = 1'b0;
        was_unique_unused_s = 1'b0;
        for (int i = 0; i < NoMstPorts; i++) begin
            was_unique_unused_s = was_unique_unused_s | resp_s[i].was_unique;
            if (cr_hs_s[i]) begin
                cr_data_s[i] = resp_s[i].data_xfer;
                cr_err_s     = cr_err_s | resp_s[i].error;
                cr_dirty_s   = cr_dirty_s | resp_s[i].pass_dirty;
                cr_shared_s  = cr_shared_s | resp_s[i].is_shared;
            end else begin
                cr_data_s[i] = 1'b0;
            end
        end
    end

    ccu_lzc_sel #(
        .Width    (NoMstPorts),
        .IdxWidth (IdxWidth)
    ) u_sel (
        .bits  (data_mask_r),
        .idx   (sel_idx_s),
        .empty (sel_empty_s)
    );

    // One-hot selected port and its CD channel.
    always_comb begin
        sel_oh_s       = '0;
        cd_valid_sel_s = 1'b0;
        cd_last_sel_s  = 1'b0;
        dat_data_s     = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            if (!sel_empty_s && (int'(sel_idx_s) == i)) begin
                sel_oh_s[i]    = 1'b1;
                cd_valid_sel_s = cd_valid_i[i];
                cd_last_sel_s  = cd_last_i[i];
                dat_data_s     = cd_data_i[i*DataWidth +: DataWidth];
            end else begin
                sel_oh_s[i] = 1'b0;
            end
        end
    end

    // Once the selected line is complete, further CD on that port is not taken.
    assign sel_active_s  = (state_r == DATA) && !sel_done_r;
    assign dat_valid_s   = sel_active_s & cd_valid_sel_s;
    assign dat_last_s    = sel_active_s && (cnt_r == LastBeat);
    assign dat_hs_s      = dat_valid_s & dat_ready_i;
    assign dat_valid_o   = dat_valid_s;
    assign dat_last_o    = dat_last_s;
    assign dat_data_o    = sel_active_s ? dat_data_s : '0;

    assign drain_ports_s = data_mask_r & ~sel_oh_s;
    assign drain_ready_s = (state_r == DATA) ? (drain_ports_s & ~drain_done_r) : '0;
    assign drain_hs_s    = drain_ready_s & cd_valid_i & cd_last_i;
    assign cd_ready_o    = drain_ready_s | (sel_oh_s & {NoMstPorts{sel_active_s & dat_ready_i}});

    assign all_drain_s   = (((drain_done_r | drain_hs_s) & drain_ports_s) == drain_ports_s);
    assign sel_fin_s     = sel_done_r | (dat_hs_s & dat_last_s);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake/result outputs.
    always_comb begin
        state_s      = state_r;
        job_ready_o  = 1'b0;
        res_valid_o  = 1'b0;
        res_data_o   = 1'b0;
        res_dirty_o  = 1'b0;
        res_shared_o = 1'b0;
        res_err_o    = 1'b0;
        busy_o       = 1'b1;
        case (state_r)
            IDLE: begin
                busy_o      = 1'b0;
                job_ready_o = ~rst_i;
                if (job_valid_i) begin
                    state_s = (new_mask_s == '0) ? RESULT : SNOOP;
                end else begin
                    state_s = IDLE;
                end
            end
            SNOOP: begin
                if ((cr_done_r | cr_hs_s) == snp_mask_r) begin
                    state_s = RESULT;
                end else begin
                    state_s = SNOOP;
                end
            end
            RESULT: begin
                res_valid_o  = 1'b1;
                res_data_o   = ~sel_empty_s;
                res_dirty_o  = dirty_r;
                res_shared_o = shared_r;
                res_err_o    = err_r;
                if (res_ready_i) begin
                    state_s = sel_empty_s ? IDLE : DATA;
                end else begin
                    state_s = RESULT;
                end
            end
            DATA: begin
                if (sel_fin_s && all_drain_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Job payload, handshake masks, merged result and beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_r       <= '0;
            snoop_r      <= 4'b0000;
            prot_r       <= 3'b000;
            snp_mask_r   <= '0;
            ac_done_r    <= '0;
            cr_done_r    <= '0;
            data_mask_r  <= '0;
            drain_done_r <= '0;
            dirty_r      <= 1'b0;
            shared_r     <= 1'b0;
            err_r        <= 1'b0;
            last_err_r   <= 1'b0;
            cnt_r        <= '0;
            sel_done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (job_valid_i) begin
                        addr_r     <= job_addr_i;
                        snoop_r    <= job_snoop_i;
                        prot_r     <= job_prot_i;
                        snp_mask_r <= new_mask_s;
                        dirty_r    <= 1'b0;
                        shared_r   <= 1'b0;
                        // An empty snoop reports all-zero; a pending line error waits.
                        if (new_mask_s == '0) begin
                            err_r <= 1'b0;
                        end else begin
                            err_r      <= last_err_r;
                            last_err_r <= 1'b0;
                        end
                    end else begin
                        err_r <= err_r;
                    end
                end
                SNOOP: begin
                    ac_done_r   <= ac_done_r | ac_hs_s;
                    cr_done_r   <= cr_done_r | cr_hs_s;
                    data_mask_r <= data_mask_r | cr_data_s;
                    err_r       <= err_r | cr_err_s;
                    dirty_r     <= dirty_r | cr_dirty_s;
                    shared_r    <= shared_r | cr_shared_s;
                end
                RESULT: begin
                    err_r <= err_r;
                end
                DATA: begin
                    drain_done_r <= drain_done_r | drain_hs_s;
                    if (dat_hs_s) begin
                        if (cd_last_sel_s != dat_last_s) begin
                            last_err_r <= 1'b1;
                        end else begin
                            last_err_r <= last_err_r;
                        end
                        // The beat counter, not CD last, decides completion.
                        if (dat_last_s) begin
                            sel_done_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CntWidth'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
            if ((state_r != IDLE) && (state_s == IDLE)) begin
                ac_done_r    <= '0;
                cr_done_r    <= '0;
                data_mask_r  <= '0;
                drain_done_r <= '0;
                cnt_r        <= '0;
                sel_done_r   <= 1'b0;
            end else begin
                sel_done_r <= sel_done_r | (dat_hs_s & dat_last_s);
            end
        end
    end

endmodule

// File: tb/tb_ccu_snoop_ctrl.sv
module tb_ccu_snoop_ctrl;
    import ccu_pkg::*;

    localparam int N  = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          job_valid_i = 1'b0;
    logic          job_ready_o;
    logic [63:0]   job_addr_i = '0;
    logic [3:0]    job_snoop_i = '0;
    logic [2:0]    job_prot_i = '0;
    logic [1:0]    job_init_i = '0;
    logic [N-1:0]  ac_valid_o, ac_ready_i = '0;
    logic [63:0]   ac_addr_o;
    logic [3:0]    ac_snoop_o;
    logic [2:0]    ac_prot_o;
    logic [N-1:0]  cr_valid_i = '0, cr_ready_o;
    logic [5*N-1:0] cr_resp_i = '0;
    logic [N-1:0]  cd_valid_i = '0, cd_ready_o, cd_last_i = '0;
    logic [64*N-1:0] cd_data_i = '0;
    logic          res_valid_o, res_ready_i = 1'b0;
    logic          res_data_o, res_dirty_o, res_shared_o, res_err_o;
    logic          dat_valid_o, dat_ready_i = 1'b0, dat_last_o;
    logic [63:0]   dat_data_o;
    logic          busy_o;

    // single-port instance
    logic          job_valid1 = 1'b0, job_ready1;
    logic [63:0]   ac_addr1;
    logic [3:0]    ac_snoop1;
    logic [2:0]    ac_prot1;
    logic [0:0]    job_init1 = 1'b0, ac_valid1, cr_ready1, cd_ready1, cd_last1;
    logic          res_valid1, res_ready1 = 1'b0, res_data1, res_dirty1, res_shared1, res_err1;
    logic          dat_valid1, dat_last1, busy1;
    logic [63:0]   dat_data1;

    always #5 clk = ~clk;

    ccu_snoop_ctrl #(.NoMstPorts(N), .AddrWidth(64), .DataWidth(64), .DataBeats(DB)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_addr_i(job_addr_i), .job_snoop_i(job_snoop_i), .job_prot_i(job_prot_i),
        .job_init_i(job_init_i), .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
        .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
        .cd_last_i(cd_last_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_dirty_o(res_dirty_o), .res_shared_o(res_shared_o),
        .res_err_o(res_err_o), .dat_valid_o(dat_valid_o), .dat_ready_i(dat_ready_i),
        .dat_data_o(dat_data_o), .dat_last_o(dat_last_o), .busy_o(busy_o)
    );

    ccu_snoop_ctrl #(.NoMstPorts(1), .AddrWidth(64), .DataWidth(64), .DataBeats(DB)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .job_valid_i(job_valid1), .job_ready_o(job_ready1),
        .job_addr_i(64'h1234), .job_snoop_i(MakeInvalid), .job_prot_i(3'b000),
        .job_init_i(job_init1), .ac_valid_o(ac_valid1), .ac_ready_i(1'b1),
        .ac_addr_o(ac_addr1), .ac_snoop_o(ac_snoop1), .ac_prot_o(ac_prot1),
        .cr_valid_i(1'b0), .cr_ready_o(cr_ready1), .cr_resp_i(5'b00000),
        .cd_valid_i(1'b0), .cd_ready_o(cd_ready1), .cd_data_i(64'h0),
        .cd_last_i(cd_last1), .res_valid_o(res_valid1), .res_ready_i(res_ready1),
        .res_data_o(res_data1), .res_dirty_o(res_dirty1), .res_shared_o(res_shared1),
        .res_err_o(res_err1), .dat_valid_o(dat_valid1), .dat_ready_i(1'b1),
        .dat_data_o(dat_data1), .dat_last_o(dat_last1), .busy_o(busy1)
    );
    assign cd_last1 = 1'b0;

    int total = 0;
    int bad = 0;
    // per-job stimulus configuration
    int         ac_dly [N];
    int         cr_dly [N];
    logic [4:0] resp [N];
    int         dr_mode = 0;
    bit         bad_last = 0;
    int         rst_beats = -1;
    bit         pend_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int p, input int b);
        return 64'(32'h80 + p * 16 + b);
    endfunction

    task automatic clear_ports();
        ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0;
        cd_valid_i = '0; cd_last_i = '0; cd_data_i = '0;
        res_ready_i = 1'b0; dat_ready_i = 1'b0;
    endtask

    task automatic run_job(input int init, input logic [3:0] snp);
        logic [N-1:0] m, dmask, ac_seen, cr_seen, exp_acv, exp_crr, exp_cdr, took;
        logic exp_dirty, exp_shared, exp_err, exp_dv;
        logic [63:0] addr;
        logic [2:0]  prot;
        int sel, phase, cyc, fwd;
        int bsent [N];
        m = '0; dmask = '0; ac_seen = '0; cr_seen = '0; took = '0;
        exp_dirty = 1'b0; exp_shared = 1'b0; exp_err = 1'b0;
        for (int p = 0; p < N; p++) begin
            bsent[p] = 0;
            m[p] = (p != init);
            if (m[p]) begin
                dmask[p]   = resp[p][0];
                exp_err    = exp_err | resp[p][1];
                exp_dirty  = exp_dirty | resp[p][2];
                exp_shared = exp_shared | resp[p][3];
            end
        end
        if (m != '0) begin
            exp_err = exp_err | pend_err;
            pend_err = 0;
        end
        sel = -1;
        for (int p = N - 1; p >= 0; p--) if (dmask[p]) sel = p;
        addr = {$urandom, $urandom};
        prot = 3'($urandom_range(0, 7));
        fwd = 0;

        @(negedge clk);
        clear_ports();
        job_valid_i = 1'b1; job_addr_i = addr; job_snoop_i = snp;
        job_prot_i = prot; job_init_i = 2'(init);
        #1;
        chk("idle_ready", {63'd0, job_ready_o}, 64'd1);
        chk("idle_busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        job_valid_i = 1'b0;
        phase = (m != '0) ? 1 : 2;
        cyc = 0;
        while (phase != 0 && cyc < 300) begin
            if (rst_beats >= 0 && phase == 3 && bsent[sel] == rst_beats) begin
                rst_i = 1'b1;
                clear_ports();
                @(negedge clk);
                #1;
                chk("rst_busy", {63'd0, busy_o}, 64'd0);
                chk("rst_vr", {56'd0, ac_valid_o, cr_ready_o}, 64'd0);
                chk("rst_cd", {60'd0, cd_ready_o}, 64'd0);
                chk("rst_out", {59'd0, res_valid_o, dat_valid_o, job_ready_o, res_err_o, dat_last_o}, 64'd0);
                pend_err = 0;
                rst_i = 1'b0;
                return;
            end
            // drive the masters
            for (int p = 0; p < N; p++) begin
                ac_ready_i[p] = (cyc >= ac_dly[p]);
                cr_valid_i[p] = m[p] && !cr_seen[p] && (cyc >= cr_dly[p]);
                cr_resp_i[5*p +: 5] = resp[p];
                if (dmask[p] && cr_seen[p] && bsent[p] < DB) begin
                    if (!(cd_valid_i[p] && !took[p])) cd_valid_i[p] = ($urandom_range(0, 3) != 0);
                    cd_data_i[64*p +: 64] = pat(p, bsent[p]);
                    cd_last_i[p] = (bsent[p] == DB - 1) ^ (bad_last && p == sel && bsent[p] == 0);
                end else begin
                    cd_valid_i[p] = 1'b0; cd_last_i[p] = 1'b0;
                end
            end
            dat_ready_i = (dr_mode == 0) ? 1'b1 : (dr_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            res_ready_i = 1'($urandom_range(0, 1));
            took = '0;
            #1;
            chk("busy", {63'd0, busy_o}, 64'd1);
            chk("job_ready", {63'd0, job_ready_o}, 64'd0);
            exp_acv = (phase == 1) ? (m & ~ac_seen) : '0;
            exp_crr = (phase == 1) ? (ac_seen & ~cr_seen) : '0;
            chk("ac_valid", {60'd0, ac_valid_o}, {60'd0, exp_acv});
            chk("cr_ready", {60'd0, cr_ready_o}, {60'd0, exp_crr});
            chk("res_valid", {63'd0, res_valid_o}, {63'd0, phase == 2});
            if (phase == 1) begin
                chk("ac_addr", ac_addr_o, addr);
                chk("ac_snp_prot", {57'd0, ac_snoop_o, ac_prot_o}, {57'd0, snp, prot});
            end
            if (phase == 2) begin
                chk("res_fields", {60'd0, res_data_o, res_dirty_o, res_shared_o, res_err_o},
                    {60'd0, dmask != '0, exp_dirty, exp_shared, exp_err});
            end
            exp_dv = (phase == 3) && cd_valid_i[sel] && (bsent[sel] < DB);
            chk("dat_valid", {63'd0, dat_valid_o}, {63'd0, exp_dv});
            exp_cdr = '0;
            if (phase == 3) begin
                for (int p = 0; p < N; p++)
                    exp_cdr[p] = (p == sel) ? (bsent[p] < DB && dat_ready_i) : (dmask[p] && bsent[p] < DB);
                if (exp_dv) begin
                    chk("dat_data", dat_data_o, pat(sel, bsent[sel]));
                    chk("dat_last", {63'd0, dat_last_o}, {63'd0, bsent[sel] == DB - 1});
                end
            end
            chk("cd_ready", {60'd0, cd_ready_o}, {60'd0, exp_cdr});
            // model update for the coming edge
            if (phase == 1) begin
                cr_seen = cr_seen | (exp_crr & cr_valid_i);
                ac_seen = ac_seen | (exp_acv & ac_ready_i);
                if (cr_seen == m) phase = 2;
            end else if (phase == 2) begin
                if (res_ready_i) phase = (dmask != '0) ? 3 : 0;
            end else begin
                for (int p = 0; p < N; p++) begin
                    if (exp_cdr[p] && cd_valid_i[p]) begin
                        bsent[p]++; took[p] = 1'b1;
                        if (p == sel) fwd++;
                    end
                end
                phase = 0;
                for (int p = 0; p < N; p++) if (dmask[p] && bsent[p] < DB) phase = 3;
            end
            @(negedge clk);
            cyc++;
        end
        chk("job_finished", 64'(cyc < 300), 64'd1);
        if (sel >= 0) chk("beats_fwd", 64'(fwd), 64'(DB));
        if (bad_last && sel >= 0) pend_err = 1;
        clear_ports();
        #1;
        chk("end_busy", {63'd0, busy_o}, 64'd0);
        chk("end_ready", {63'd0, job_ready_o}, 64'd1);
    endtask

    task automatic set_cfg(input int ad, input int cd, input logic [4:0] r0, input logic [4:0] r1,
                           input logic [4:0] r2, input logic [4:0] r3);
        for (int p = 0; p < N; p++) begin ac_dly[p] = ad; cr_dly[p] = cd; end
        resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy0", {63'd0, busy_o}, 64'd0);
        chk("rst_outs0", {62'd0, res_valid_o, dat_valid_o}, 64'd0);
        chk("rst_ac0", {60'd0, ac_valid_o}, 64'd0);
        chk("rst_addr0", ac_addr_o, 64'd0);
        rst_i = 1'b0;

        // plain broadcast, no data, all ready at once
        set_cfg(0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        run_job(0, ReadShared);
        // port 2 AC stalled 5 cycles, early CR on all ports
        set_cfg(0, 0, 5'd0, 5'b01000, 5'd0, 5'd0);
        ac_dly[2] = 5;
        run_job(0, CleanInvalid);
        // ports 2 and 3 return data, port 3 PassDirty
        set_cfg(1, 2, 5'd0, 5'd0, 5'b00001, 5'b00101);
        run_job(0, ReadShared);
        // same with dat_ready toggling
        dr_mode = 1;
        run_job(0, ReadShared);
        // wrong CD last on the forwarded line, error reported on the next job
        dr_mode = 0; bad_last = 1;
        set_cfg(0, 0, 5'b00001, 5'd0, 5'b00001, 5'd0);
        run_job(3, ReadShared);
        bad_last = 0;
        set_cfg(0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        run_job(1, MakeInvalid);
        // randomized jobs
        dr_mode = 2;
        for (int j = 0; j < 14; j++) begin
            for (int p = 0; p < N; p++) begin
                ac_dly[p] = $urandom_range(0, 3);
                cr_dly[p] = $urandom_range(0, 4);
                resp[p]   = 5'($urandom_range(0, 31));
            end
            run_job($urandom_range(0, 3), ReadShared);
        end
        // reset in DATA after 2 beats, then a fresh job
        dr_mode = 0; rst_beats = 2;
        set_cfg(0, 0, 5'd0, 5'b00001, 5'd0, 5'b00001);
        run_job(0, ReadShared);
        rst_beats = -1;
        run_job(2, ReadShared);

        // single-port instance: initiator is the only port
        @(negedge clk);
        job_valid1 = 1'b1;
        #1;
        chk("n1_ready", {63'd0, job_ready1}, 64'd1);
        @(negedge clk);
        job_valid1 = 1'b0;
        #1;
        chk("n1_result", {61'd0, res_valid1, res_data1, busy1}, {61'd0, 1'b1, 1'b0, 1'b1});
        chk("n1_noac", {63'd0, ac_valid1}, 64'd0);
        res_ready1 = 1'b1;
        @(negedge clk);
        res_ready1 = 1'b0;
        #1;
        chk("n1_idle", {62'd0, busy1, res_valid1}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
